// File: rtl/vote_pkg.sv
// vote_pkg: shared types and constants for the voting front end.
//   state_t       : arbiter FSM states (IDLE, WAIT_RELEASE, LOCKOUT)
//   NUM_CAND      : number of candidate buttons / tallies
//   CNT_W_DEFAULT : default tally width
//   TALLY_MAX     : saturation value of a default-width tally
//   max_int       : helper for sizing the shared phase counter
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_RELEASE = 2'd1,
      LOCKOUT      = 2'd2
   } state_t;

   localparam int NUM_CAND      = 4;
   localparam int CNT_W_DEFAULT = 8;
   localparam int TALLY_MAX     = (1 << CNT_W_DEFAULT) - 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vote_tally.sv
// vote_tally: one saturating candidate tally.
//   clk, rst : clock, synchronous active-high reset (clears the tally)
//   inc      : count one vote this cycle (ignored once saturated)
//   cnt      : current tally
//   sat      : tally is at its maximum value
module vote_tally #(
   parameter int CNT_W = vote_pkg::CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   assign sat = (cnt == {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (inc && !sat)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/vote_arbiter.sv
// vote_arbiter: turns the four candidate buttons into tally increments.
// Accepts one vote per press: a press in IDLE is counted (or rejected),
// then all buttons must stay low for RELEASE_CYCLES consecutive cycles,
// followed by LOCKOUT_CYCLES cycles in which buttons are ignored.
//   clk, rst            : clock, synchronous active-high reset
//   mode                : 0 = voting, 1 = result (only looked at in IDLE)
//   cand1..4_button     : synchronised candidate buttons
//   cand1..4_vote       : candidate tallies
//   valid_vote_casted   : one-cycle pulse, vote counted
//   invalid_vote        : one-cycle pulse, press rejected (multi-press or saturated)
//   busy                : high whenever the FSM is not in IDLE
module vote_arbiter
   import vote_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEFAULT,
   parameter int RELEASE_CYCLES = 3,
   parameter int LOCKOUT_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             cand1_button,
   input  logic             cand2_button,
   input  logic             cand3_button,
   input  logic             cand4_button,
   output logic [CNT_W-1:0] cand1_vote,
   output logic [CNT_W-1:0] cand2_vote,
   output logic [CNT_W-1:0] cand3_vote,
   output logic [CNT_W-1:0] cand4_vote,
   output logic             valid_vote_casted,
   output logic             invalid_vote,
   output logic             busy
);

   localparam int PH_MAX = max_int(RELEASE_CYCLES, LOCKOUT_CYCLES);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] REL_LAST  = PH_W'(RELEASE_CYCLES - 1);
   localparam logic [PH_W-1:0] LOCK_LAST = PH_W'(LOCKOUT_CYCLES - 1);

   state_t                          state;
   logic [PH_W-1:0]                 phase;
   logic [NUM_CAND-1:0]             btn;
   logic [NUM_CAND-1:0]             sat;
   logic [NUM_CAND-1:0]             inc;
   logic [NUM_CAND-1:0][CNT_W-1:0]  tally;
   logic                            any_btn;
   logic                            one_hot;
   logic                            sel_sat;
   logic                            accept;

   assign btn     = {cand4_button, cand3_button, cand2_button, cand1_button};
   assign any_btn = |btn;
   // Clearing the lowest set bit leaves zero only for a single press.
   assign one_hot = any_btn && ((btn & (btn - 1'b1)) == '0);
   assign sel_sat = |(btn & sat);
   assign accept  = (state == IDLE) && !mode && one_hot && !sel_sat;
   assign inc     = accept ? btn : '0;

   for (genvar i = 0; i < NUM_CAND; i++) begin : g_tally
      vote_tally #(.CNT_W(CNT_W)) u_tally (
         .clk (clk),
         .rst (rst),
         .inc (inc[i]),
         .cnt (tally[i]),
         .sat (sat[i])
      );
   end

   assign cand1_vote = tally[0];
   assign cand2_vote = tally[1];
   assign cand3_vote = tally[2];
   assign cand4_vote = tally[3];

   // Reset lands in WAIT_RELEASE so a button held through reset must be
   // released and locked out before it can ever count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= WAIT_RELEASE;
         phase             <= '0;
         valid_vote_casted <= 1'b0;
         invalid_vote      <= 1'b0;
         busy              <= 1'b1;
      end else begin
         valid_vote_casted <= 1'b0;
         invalid_vote      <= 1'b0;
         case (state)
            IDLE: begin
               if (!mode && any_btn) begin
                  state             <= WAIT_RELEASE;
                  phase             <= '0;
                  busy              <= 1'b1;
                  valid_vote_casted <= accept;
                  invalid_vote      <= !accept;
               end
            end
            WAIT_RELEASE: begin
               if (any_btn) begin
                  phase <= '0;
               end else if (phase == REL_LAST) begin
                  state <= LOCKOUT;
                  phase <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            LOCKOUT: begin
               if (phase == LOCK_LAST) begin
                  state <= IDLE;
                  phase <= '0;
                  busy  <= 1'b0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: begin
               state <= WAIT_RELEASE;
               phase <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vote_arbiter.sv
module tb_vote_arbiter;

   localparam int REL  = 3;
   localparam int LOCK = 5;
   localparam int TMAX = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       cand1_button = 1'b0, cand2_button = 1'b0;
   logic       cand3_button = 1'b0, cand4_button = 1'b0;
   logic [7:0] cand1_vote, cand2_vote, cand3_vote, cand4_vote;
   logic       valid_vote_casted, invalid_vote, busy;

   int checks = 0;
   int errs   = 0;

   // Reference model: "armed" means the next press will be judged; after a
   // press we need REL consecutive quiet cycles, then LOCK ignored cycles.
   bit m_armed;
   int m_quiet, m_lock;
   int m_tally [4];
   bit m_valid, m_invalid;

   vote_arbiter u_dut (
      .clk               (clk),
      .rst               (rst),
      .mode              (mode),
      .cand1_button      (cand1_button),
      .cand2_button      (cand2_button),
      .cand3_button      (cand3_button),
      .cand4_button      (cand4_button),
      .cand1_vote        (cand1_vote),
      .cand2_vote        (cand2_vote),
      .cand3_vote        (cand3_vote),
      .cand4_vote        (cand4_vote),
      .valid_vote_casted (valid_vote_casted),
      .invalid_vote      (invalid_vote),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit m, input bit [3:0] b);
      m_valid   = 0;
      m_invalid = 0;
      if (r) begin
         foreach (m_tally[i]) m_tally[i] = 0;
         m_armed = 0; m_quiet = 0; m_lock = 0;
      end else if (m_armed) begin
         if (!m && b != 0) begin
            m_armed = 0; m_quiet = 0; m_lock = 0;
            if ($countones(b) > 1) m_invalid = 1;
            else begin
               int idx = 0;
               for (int i = 0; i < 4; i++) if (b[i]) idx = i;
               if (m_tally[idx] == TMAX) m_invalid = 1;
               else begin
                  m_tally[idx]++;
                  m_valid = 1;
               end
            end
         end
      end else if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_armed = 1;
      end else if (b != 0) begin
         m_quiet = 0;
      end else begin
         m_quiet++;
         if (m_quiet == REL) m_lock = LOCK;
      end
   endtask

   task automatic cyc(input bit r, input bit m, input bit [3:0] b);
      @(negedge clk);
      rst  = r;
      mode = m;
      {cand4_button, cand3_button, cand2_button, cand1_button} = b;
      @(posedge clk);
      model(r, m, b);
      #1;
      chk("busy",    busy,              !m_armed);
      chk("valid",   valid_vote_casted, m_valid);
      chk("invalid", invalid_vote,      m_invalid);
      chk("cand1",   cand1_vote,        m_tally[0]);
      chk("cand2",   cand2_vote,        m_tally[1]);
      chk("cand3",   cand3_vote,        m_tally[2]);
      chk("cand4",   cand4_vote,        m_tally[3]);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 4'b0000);
   endtask

   initial begin
      int lat;
      int votes;
      int hi_cnt;
      cyc(1, 0, 4'b0000);
      cyc(1, 0, 4'b0000);

      // 1: idle latency after reset with buttons low
      lat = 0;
      while (busy && lat < 20) begin
         cyc(0, 0, 4'b0000);
         lat++;
      end
      chk("idle_lat_reset", lat, 8);

      // 2: single press of cand2, pulse exactly one cycle, 8 cycles to idle
      cyc(0, 0, 4'b0010);
      chk("cand2_first", cand2_vote, 1);
      lat = 0;
      while (busy && lat < 20) begin
         cyc(0, 0, 4'b0000);
         lat++;
      end
      chk("idle_lat_release", lat, 8);

      // 3: multi-press
      cyc(0, 0, 4'b0101);
      chk("multi_invalid", invalid_vote, 1);
      idle_n(10);

      // 4: long hold of cand4, re-press during lockout, then a fresh press
      hi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 4'b1000);
         if (valid_vote_casted) hi_cnt++;
      end
      chk("hold_one_pulse", hi_cnt, 1);
      idle_n(4);
      cyc(0, 0, 4'b1000);
      idle_n(6);
      chk("cand4_after_lock", cand4_vote, 1);
      cyc(0, 0, 4'b1000);
      chk("cand4_second", cand4_vote, 2);

      // 5: bounce during release restarts the quiet count
      idle_n(1);
      cyc(0, 0, 4'b1000);
      idle_n(1);
      cyc(0, 0, 4'b1000);
      lat = 0;
      while (busy && lat < 20) begin
         cyc(0, 0, 4'b0000);
         lat++;
      end
      chk("idle_lat_bounce", lat, 8);

      // reset in the middle of a sequence with a button held
      cyc(0, 0, 4'b0001);
      cyc(1, 0, 4'b0001);
      cyc(0, 0, 4'b0001);
      idle_n(9);

      // randomized traffic, including mode flips and occasional resets
      for (int i = 0; i < 1500; i++) begin
         bit [3:0] b;
         bit m, r;
         for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 99) < 15);
         m = ($urandom_range(0, 99) < 15);
         r = ($urandom_range(0, 999) < 5);
         cyc(r, m, b);
      end
      idle_n(10);

      // 6: saturate cand1, then one more press
      votes = 0;
      while (cand1_vote != 8'd255 && votes < 300) begin
         cyc(0, 0, 4'b0001);
         idle_n(8);
         votes++;
      end
      chk("cand1_sat", cand1_vote, 255);
      cyc(0, 0, 4'b0001);
      chk("sat_invalid", invalid_vote, 1);
      chk("sat_hold", cand1_vote, 255);
      idle_n(8);
      cyc(0, 1, 4'b0001);
      chk("mode1_busy", busy, 0);
      cyc(0, 1, 4'b0000);
      idle_n(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/vote_arbiter.md
Name: vote_arbiter

Overview:
- Voting-mode front end that turns the four candidate buttons into vote-tally increments.
- Arbitrates simultaneous presses and enforces one vote per press (press, release, lockout).
- Holds the per-candidate 8-bit tallies.
- Drives cand1..4_vote and the one-cycle valid_vote_casted pulse consumed by modeControl (LED/result display).

Parameters:
- CNT_W, 8: width of each candidate tally.
- RELEASE_CYCLES, 3: consecutive all-buttons-low cycles required to accept a release (debounce).
- LOCKOUT_CYCLES, 5: idle cycles after release before the next vote is accepted.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = voting, 1 = result; votes are accepted only when mode==0.
- cand1_button  in  1  candidate 1 button, already synchronised to clk.
- cand2_button  in  1  candidate 2 button.
- cand3_button  in  1  candidate 3 button.
- cand4_button  in  1  candidate 4 button.
- cand1_vote  out  CNT_W  candidate 1 tally.
- cand2_vote  out  CNT_W  candidate 2 tally.
- cand3_vote  out  CNT_W  candidate 3 tally.
- cand4_vote  out  CNT_W  candidate 4 tally.
- valid_vote_casted  out  1  one-cycle pulse when a vote is counted.
- invalid_vote  out  1  one-cycle pulse when a press is rejected (multiple buttons, or target tally saturated).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - All tallies = 0.
  - valid_vote_casted = 0, invalid_vote = 0.
  - State = WAIT_RELEASE, phase counter = 0, busy = 1.
  - Consequence: a button held through reset never produces a vote.
- States (held in a counter-based FSM; the phase counter is wide enough for max(RELEASE_CYCLES, LOCKOUT_CYCLES)):
  - IDLE: busy=0. Buttons are sampled only when mode==0; with mode==1, buttons are ignored and the FSM stays in IDLE.
    - Exactly one button high in cycle N: at edge N+1 that tally increments and valid_vote_casted=1 for exactly that one cycle; next state is WAIT_RELEASE.
    - Two or more buttons high: no increment, invalid_vote=1 for one cycle, next state WAIT_RELEASE.
    - Single button whose tally equals 2^CNT_W-1: tally unchanged (saturating), invalid_vote=1 for one cycle, next state WAIT_RELEASE.
  - WAIT_RELEASE:
    - Each cycle with all buttons low increments the phase counter.
    - Any button high clears the phase counter to 0.
    - When the counter reaches RELEASE_CYCLES-1 with all buttons still low: go to LOCKOUT and clear the counter.
  - LOCKOUT:
    - Buttons are ignored; the phase counter increments each cycle.
    - At LOCKOUT_CYCLES-1: go to IDLE and clear the counter.
- Timing with default parameters: from release to IDLE is 8 cycles. After reset deassert with buttons low, IDLE (busy=0) is reached on the 8th cycle.
- Mode handling:
  - mode is evaluated only in IDLE.
  - Changing mode in WAIT_RELEASE or LOCKOUT does not abort the sequence.
  - mode==1 never alters tallies.
- Pulses: valid_vote_casted and invalid_vote are never high in the same cycle. Each is high for at most one cycle per press.
- Tally behaviour:
  - Tallies only increment (never wrap) and only clear on rst.
  - Tally outputs change on the same edge that valid_vote_casted rises.
- Reset mid-sequence: rst in any state takes priority over everything. Tallies clear and the state returns to WAIT_RELEASE on the next edge.

Decomposition:
- Package vote_pkg:
  - State encoding: IDLE, WAIT_RELEASE, LOCKOUT.
  - NUM_CAND = 4.
  - Default CNT_W.
  - Helper constant TALLY_MAX = 2^CNT_W-1.
- Sub-module vote_tally: one saturating CNT_W counter with inc input and sat output. Instantiated four times.
- The FSM, one-hot/multi-press decoding and phase counter live in vote_arbiter.

Test Plan:
1. Reset, then hold all buttons low → busy falls on the 8th cycle after reset deassert; all tallies 0; no pulses.
2. mode=0, IDLE, cand2_button high for 1 cycle → next cycle cand2_vote=1 and valid_vote_casted=1 for exactly 1 cycle; busy=1; after release, busy=0 8 cycles later.
3. mode=0, cand1 and cand3 high in the same cycle → invalid_vote pulses once; all tallies unchanged; FSM waits for release.
4. Hold cand4 for 20 cycles, then release → exactly one increment (cand4_vote=1). Re-press cand4 during LOCKOUT → ignored. Press after busy=0 → cand4_vote=2.
5. Bounce: release, re-press at 2nd low cycle, release → WAIT_RELEASE restarts its count; no extra vote; IDLE 8 cycles after final release.
6. Drive cand1 to 255 via 255 votes, then press again → cand1_vote stays 255 and invalid_vote pulses. With mode=1, press cand1 → no pulses, tallies unchanged.
